// File: rtl/dram_wb_arbiter.sv
// Round-robin arbiter multiplexing several Wishbone masters onto one DRAM user port,
// with a per-access ack timeout and a forced one-cycle cyc gap between owners.
module dram_wb_arbiter #(
    parameter int unsigned NUM_PORTS      = 4,
    parameter int unsigned ADDR_WIDTH     = 30,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               init_done,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]    s_adr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]    s_dat_w,
    input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] s_sel,
    input  logic [NUM_PORTS-1:0]               s_cyc,
    input  logic [NUM_PORTS-1:0]               s_stb,
    input  logic [NUM_PORTS-1:0]               s_we,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]    s_dat_r,
    output logic [NUM_PORTS-1:0]               s_ack,
    output logic [NUM_PORTS-1:0]               s_err,
    output logic [ADDR_WIDTH-1:0]              m_adr,
    output logic [DATA_WIDTH-1:0]              m_dat_w,
    output logic [DATA_WIDTH/8-1:0]            m_sel,
    output logic                               m_cyc,
    output logic                               m_stb,
    output logic                               m_we,
    input  logic [DATA_WIDTH-1:0]              m_dat_r,
    input  logic                               m_ack,
    input  logic                               m_err,
    output logic                               grant_valid,
    output logic [2:0]                         grant_id,
    output logic [15:0]                        timeout_count
);

    localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StOwn, StRelease} state_e;

    state_e         state_q, state_d;
    logic [2:0]     grant_q, grant_d;
    logic [2:0]     last_grant_q, last_grant_d;
    logic [15:0]    tmo_cnt_q, tmo_cnt_d;
    logic [15:0]    timeout_count_q, timeout_count_d;

    logic [NUM_PORTS-1:0] req;
    logic                 found;
    logic [2:0]           winner;
    logic                 own;
    logic                 g_cyc, g_stb;
    logic                 timeout_hit;

    assign req = s_cyc & s_stb;

    // Round-robin pick: first requester searching upward from last_grant+1.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (!found && req[i] && (i == (32'(last_grant_q) + k) % NUM_PORTS)) begin
                    found  = 1'b1;
                    winner = 3'(i);
                end
            end
        end
    end

    // Datapath mux and completion routing; everything is forced low outside OWN or in reset.
    always_comb begin
        own         = (state_q == StOwn) && rst;
        g_cyc       = 1'b0;
        g_stb       = 1'b0;
        m_adr       = '0;
        m_dat_w     = '0;
        m_sel       = '0;
        m_we        = 1'b0;
        s_ack       = '0;
        s_err       = '0;
        s_dat_r     = {NUM_PORTS{m_dat_r}};
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (own && (3'(i) == grant_q)) begin
                g_cyc   = s_cyc[i];
                g_stb   = s_stb[i];
                m_adr   = s_adr[i*ADDR_WIDTH +: ADDR_WIDTH];
                m_dat_w = s_dat_w[i*DATA_WIDTH +: DATA_WIDTH];
                m_sel   = s_sel[i*SEL_WIDTH +: SEL_WIDTH];
                m_we    = s_we[i];
            end
        end
        // Timeout cycle: ack/err from DRAM is ignored and the master sees err instead.
        timeout_hit = own && g_cyc && g_stb && (tmo_cnt_q == TMO_LAST);
        m_cyc       = g_cyc && !timeout_hit;
        m_stb       = g_stb && !timeout_hit;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (own && (3'(i) == grant_q)) begin
                s_ack[i] = m_ack && !timeout_hit;
                s_err[i] = m_err || timeout_hit;
            end
        end
        grant_valid   = own;
        grant_id      = own ? grant_q : 3'd0;
        timeout_count = timeout_count_q;
    end

    // Next-state logic for ownership FSM and timeout counters.
    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        last_grant_d    = last_grant_q;
        tmo_cnt_d       = tmo_cnt_q;
        timeout_count_d = timeout_count_q;
        unique case (state_q)
            StIdle: begin
                if (init_done && found) begin
                    grant_d      = winner;
                    last_grant_d = winner;
                    tmo_cnt_d    = '0;
                    state_d      = StOwn;
                end
            end
            StOwn: begin
                if (!g_cyc) begin
                    state_d = StRelease;
                end else if (timeout_hit) begin
                    state_d   = StRelease;
                    tmo_cnt_d = '0;
                    if (timeout_count_q != 16'hFFFF) begin
                        timeout_count_d = timeout_count_q + 16'd1;
                    end
                end else if (m_ack || m_err) begin
                    tmo_cnt_d = '0;
                end else if (g_stb) begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            StRelease: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q         <= StIdle;
            grant_q         <= '0;
            last_grant_q    <= 3'(NUM_PORTS - 1);
            tmo_cnt_q       <= '0;
            timeout_count_q <= '0;
        end else begin
            state_q         <= state_d;
            grant_q         <= grant_d;
            last_grant_q    <= last_grant_d;
            tmo_cnt_q       <= tmo_cnt_d;
            timeout_count_q <= timeout_count_d;
        end
    end

endmodule
